// File: rtl/delay_pipe_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// delay_pipe_scheduler_pkg : shared defaults, source tags and stage record
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package delay_pipe_scheduler_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 6;

  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic                 src;
    logic [WIDTH_DEF-1:0] data;
  } stage_t;

endpackage

`default_nettype wire

// File: rtl/delay_pipe_scheduler_pipe_stage.sv
// ----------------------------------------------------------------------------
// pipe_stage : one enable-gated stage register holding a {valid, src, data} record
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_stage
  import delay_pipe_scheduler_pkg::*;
#(
  parameter type REC_T = stage_t
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  input  REC_T d,
  output REC_T q
);

  // clr drops only the valid bit; src/data keep their last contents
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q <= '0;
    end else if (clr) begin
      q.valid <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/delay_pipe_scheduler.sv
// ----------------------------------------------------------------------------
// delay_pipe_scheduler : two-requester round-robin front end for a fixed-depth delay line
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module delay_pipe_scheduler
  import delay_pipe_scheduler_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       req0_valid,
  input  logic [WIDTH-1:0]           req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [WIDTH-1:0]           req1_data,
  output logic                       req1_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_src,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic             valid;
    logic             src;
    logic [WIDTH-1:0] data;
  } rec_t;

  rec_t stage_q [DEPTH];
  rec_t head;
  logic last_grant;
  logic stall;
  logic advance;
  logic grant0;
  logic grant1;
  logic accept;
  logic deliver;

  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_src   = stage_q[DEPTH-1].src;
  assign out_data  = stage_q[DEPTH-1].data;

  assign stall   = out_valid & ~out_ready;
  assign advance = ~stall & ~flush & ~RESET;

  // A tie goes to whichever requester was not served last
  always_comb begin
    grant0 = req0_valid & (~req1_valid | (last_grant == SRC_REQ1));
    grant1 = req1_valid & (~req0_valid | (last_grant == SRC_REQ0));
    head       = stage_q[0];
    head.valid = 1'b0;
    if (grant0) begin
      head.valid = 1'b1;
      head.src   = SRC_REQ0;
      head.data  = req0_data;
    end else if (grant1) begin
      head.valid = 1'b1;
      head.src   = SRC_REQ1;
      head.data  = req1_data;
    end
  end

  assign req0_ready = advance & grant0;
  assign req1_ready = advance & grant1;
  assign accept     = advance & (grant0 | grant1);
  // On advance the last stage is always shifted out, so a valid word there is delivered
  assign deliver    = advance & out_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    rec_t d_in;
    if (i == 0) begin : g_first
      assign d_in = head;
    end else begin : g_next
      assign d_in = stage_q[i-1];
    end
    pipe_stage #(
      .REC_T (rec_t)
    ) u_stage (
      .CLK   (CLK),
      .RESET (RESET),
      .en    (advance),
      .clr   (flush),
      .d     (d_in),
      .q     (stage_q[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_grant <= SRC_REQ1;
    end else if (accept) begin
      last_grant <= grant1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      occupancy <= '0;
    end else if (accept && !deliver) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (!accept && deliver) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_delay_pipe_scheduler.sv
// ----------------------------------------------------------------------------
// tb_delay_pipe_scheduler : directed self-checking bench for delay_pipe_scheduler
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_delay_pipe_scheduler;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req0_valid;
  logic [3:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_data;
  logic       req1_ready;
  logic       flush;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_src;
  logic       out_ready;
  logic [2:0] occupancy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  delay_pipe_scheduler #(
    .WIDTH (4),
    .DEPTH (6)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .occupancy  (occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [3:0] d0, input logic v1,
                       input logic [3:0] d1, input logic ordy, input logic fl,
                       input logic rst);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    out_ready  = ordy;
    flush      = fl;
    RESET      = rst;
  endtask

  initial begin
    // reset with both requesters asserting
    drive(1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);

    // single word: accepted now, visible exactly 6 cycles later for one cycle
    drive(1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("single_req0_ready", 32'(req0_ready), 1);
    chk("single_req1_ready", 32'(req1_ready), 0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("single_out_valid", 32'(out_valid), (k == 6) ? 1 : 0);
      if (k == 6) begin
        chk("single_out_data", 32'(out_data), 32'hA);
        chk("single_out_src", 32'(out_src), 0);
      end
      chk("single_occupancy", 32'(occupancy), (k <= 6) ? 1 : 0);
    end

    // contention: reset first so req0 wins the first tie
    @(negedge CLK);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      drive(1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
      #1;
      chk("cont_req0_ready", 32'(req0_ready), (i % 2 == 0) ? 1 : 0);
      chk("cont_req1_ready", 32'(req1_ready), (i % 2 == 1) ? 1 : 0);
      chk("cont_out_valid", 32'(out_valid), (i >= 6) ? 1 : 0);
      if (i >= 6) begin
        chk("cont_out_data", 32'(out_data), ((i - 6) % 2 == 0) ? 1 : 2);
        chk("cont_out_src", 32'(out_src), ((i - 6) % 2 == 0) ? 0 : 1);
      end
      chk("cont_occupancy", 32'(occupancy), (i < 6) ? i : 6);
    end

    // backpressure: fill with 3..8 and stall for 4 cycles
    @(negedge CLK);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      @(negedge CLK);
      drive(1'b1, 4'(3 + j), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("fill_req0_ready", 32'(req0_ready), 1);
      chk("fill_occupancy", 32'(occupancy), j);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      drive(1'b1, 4'h9, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
      #1;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_data", 32'(out_data), 3);
      chk("bp_req0_ready", 32'(req0_ready), 0);
      chk("bp_req1_ready", 32'(req1_ready), 0);
      chk("bp_occupancy", 32'(occupancy), 6);
    end
    for (int m = 0; m < 6; m++) begin
      @(negedge CLK);
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("drain_out_valid", 32'(out_valid), 1);
      chk("drain_out_data", 32'(out_data), 3 + m);
      chk("drain_occupancy", 32'(occupancy), 6 - m);
    end

    // bubble stall: lone word 5 stalls at the output, chain must not accept
    @(negedge CLK);
    drive(1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bub_occupancy0", 32'(occupancy), 0);
    chk("bub_req0_ready", 32'(req0_ready), 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("bub_out_valid_early", 32'(out_valid), 0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      drive(1'b0, 4'h0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
      #1;
      chk("bub_out_valid", 32'(out_valid), 1);
      chk("bub_out_data", 32'(out_data), 5);
      chk("bub_req1_ready", 32'(req1_ready), 0);
      chk("bub_occupancy", 32'(occupancy), 1);
    end
    @(negedge CLK);
    drive(1'b0, 4'h0, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    #1;
    chk("bub_release_out_data", 32'(out_data), 5);
    chk("bub_release_req1_ready", 32'(req1_ready), 1);

    // flush with 4 words in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      drive(1'b1, 4'(12 + k), 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("pre_flush_req0_ready", 32'(req0_ready), 1);
      chk("pre_flush_occupancy", 32'(occupancy), 1 + k);
    end
    @(negedge CLK);
    drive(1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("flush_occupancy", 32'(occupancy), 4);
    chk("flush_req0_ready", 32'(req0_ready), 0);
    @(negedge CLK);
    drive(1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("post_flush_occupancy", 32'(occupancy), 0);
    chk("post_flush_out_valid", 32'(out_valid), 0);
    chk("post_flush_req0_ready", 32'(req0_ready), 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      drive(1'b1, 4'(k), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("post_flush_out_valid_k", 32'(out_valid), 0);
      chk("refill_req0_ready", 32'(req0_ready), 1);
    end
    @(negedge CLK);
    drive(1'b1, 4'hB, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush_new_out_valid", 32'(out_valid), 1);
    chk("flush_new_out_data", 32'(out_data), 9);
    chk("flush_new_out_src", 32'(out_src), 0);
    chk("full_occupancy", 32'(occupancy), 6);
    chk("full_req0_ready", 32'(req0_ready), 0);
    chk("full_req1_ready", 32'(req1_ready), 0);

    // reset mid-stream with a full stalled chain
    @(negedge CLK);
    drive(1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    drive(1'b1, 4'h4, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_data", 32'(out_data), 0);
    chk("mid_rst_out_src", 32'(out_src), 0);
    chk("mid_rst_occupancy", 32'(occupancy), 0);
    chk("mid_rst_tie_req0", 32'(req0_ready), 1);
    chk("mid_rst_tie_req1", 32'(req1_ready), 0);
    @(negedge CLK);
    drive(1'b1, 4'h4, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mid_rst_next_req0", 32'(req0_ready), 0);
    chk("mid_rst_next_req1", 32'(req1_ready), 1);

    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
